pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Generic elastic pipeline-stage register for the core's inter-stage
//   boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries one packed payload
//   with a valid/ready handshake, optional 2-entry skid buffer, synchronous
//   flush and bubble insertion. Replaces hand-built per-stage enable registers.
//   Includes a saturating backpressure counter for performance debug.
// PARAMETERS
//   WIDTH    32            payload width in bits (>=1)
//   NOP_VAL  32'h00000013  value driven on out_data while out_valid=0 (RV32 addi x0,x0,0), width WIDTH
//   SKID     1             1: 2-entry skid buffer, registered in_ready; 0: single entry, combinational in_ready
//   CNT_W    16            width of stall_cnt (>=1)
// PORTS
//   clk        in   1        clock, all state updates on rising edge
//   rst        in   1        synchronous active-high reset
//   flush      in   1        kill all held entries (branch mispredict / trap)
//   in_valid   in   1        upstream presents in_data
//   in_ready   out  1        stage can accept this cycle
//   in_data    in   WIDTH    upstream payload
//   out_valid  out  1        stage presents out_data
//   out_ready  in   1        downstream accepts this cycle
//   out_data   out  WIDTH    payload; NOP_VAL when out_valid=0
//   occupancy  out  2        entries held (0..2; max 1 when SKID=0)
//   stall_cnt  out  CNT_W    cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//   - Reset: one clock; reset is synchronous and active-high. While rst=1 and on the
//     cycle after: main valid M_v=0, skid valid S_v=0, out_valid=0,
//     out_data=NOP_VAL, occupancy=0, stall_cnt=0. in_ready=0 while rst=1.
//   - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   - out_valid = M_v; out_data = M_v ? M : NOP_VAL; occupancy = M_v + S_v.
//   - Latency: accepted word appears on out_data the next cycle if M is free.
//   - SKID=1: in_ready = ~S_v (register-driven, no comb path from out_ready).
//       if (~M_v | out_fire): S_v ? (M<=S, M_v<=1, S_v<=0) : (M<=in_data, M_v<=in_fire)
//       else if in_fire: S<=in_data, S_v<=1   (M held, word parked in skid)
//     Order preserved: S always drains to M before any new input reaches M.
//   - SKID=0: in_ready = ~M_v | out_ready; if in_ready: M<=in_data, M_v<=in_fire.
//     S_v tied 0.
//   - Full (occupancy=2): in_ready=0; in_data ignored regardless of in_valid.
//   - Empty: out_valid=0; out_ready ignored; stall_cnt does not count.
//   - Flush (priority below rst, above all else): next cycle M_v=S_v=0.
//     in_fire in the flush cycle is discarded; out_fire in the flush cycle is a
//     completed transfer. in_ready in flush cycle follows the normal rule.
//   - stall_cnt: +1 each cycle with out_valid & ~out_ready (including flush cycle),
//     holds at 2^CNT_W-1, cleared only by rst.
//   - Payload regs M,S need no reset; outputs masked by valid.
// TESTING
//   1 SKID=1, out_ready=1, in_valid=1 with 1,2,3,4 -> out_data 1,2,3,4 one cycle
//     later each, in_ready constant 1, occupancy<=1, stall_cnt=0.
//   2 SKID=1, out_ready=0, push A=0xA,B=0xB,C=0xC -> A in M, B in skid, occupancy=2,
//     in_ready=0 so C held upstream; raise out_ready -> A,B,C out in order, no loss/dup.
//   3 occupancy=2 then flush=1 with in_valid=1 -> next cycle out_valid=0,
//     out_data=0x00000013, occupancy=0, input word dropped.
//   4 CNT_W=4, hold valid entry with out_ready=0 for 20 cycles -> stall_cnt=15 (sat).
//   5 occupancy=2 and stall_cnt=7, assert rst one cycle -> all outputs at reset
//     values; next push 0x55 appears normally.
//   6 SKID=0, M_v=1, out_ready=1 and in_valid=1 same cycle -> in_ready=1 comb,
//     back-to-back transfer, occupancy stays 1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready payload slot with an optional skid entry,
// synchronous flush and a saturating backpressure counter.
module pipe_stage_reg #(
    parameter int unsigned        WIDTH   = 32,
    parameter logic [WIDTH-1:0]   NOP_VAL = WIDTH'(32'h0000_0013),
    parameter int unsigned        SKID    = 1,
    parameter int unsigned        CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             m_v;
    logic             s_v;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] s_q;

    logic             m_v_nxt;
    logic             s_v_nxt;
    logic [WIDTH-1:0] m_d;
    logic [WIDTH-1:0] s_d;

    logic             in_fire;
    logic             out_fire;

    // With a skid entry, ready depends only on skid state, breaking the out_ready->in_ready path.
    assign in_ready  = rst ? 1'b0 : ((SKID != 0) ? ~s_v : (~m_v | out_ready));
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = m_v & out_ready;

    assign out_valid = m_v;
    assign out_data  = m_v ? m_q : NOP_VAL;
    assign occupancy = 2'(m_v) + 2'(s_v);

    // Next-state for the main and skid slots; skid always drains into main before new input.
    always_comb begin
        m_v_nxt = m_v;
        s_v_nxt = s_v;
        m_d     = m_q;
        s_d     = s_q;
        if (SKID != 0) begin
            if (~m_v | out_fire) begin
                if (s_v) begin
                    m_d     = s_q;
                    m_v_nxt = 1'b1;
                    s_v_nxt = 1'b0;
                end else begin
                    m_d     = in_data;
                    m_v_nxt = in_fire;
                end
            end else if (in_fire) begin
                s_d     = in_data;
                s_v_nxt = 1'b1;
            end
        end else begin
            s_v_nxt = 1'b0;
            if (in_ready) begin
                m_d     = in_data;
                m_v_nxt = in_fire;
            end
        end
        if (flush) begin
            m_v_nxt = 1'b0;
            s_v_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
        end else begin
            m_v <= m_v_nxt;
            s_v <= s_v_nxt;
        end
    end

    // Payload needs no reset: it is only observed through the valid mask.
    always_ff @(posedge clk) begin
        m_q <= m_d;
        s_q <= s_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (m_v && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid instance (CNT_W=4) and single-entry instance.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic [3:0]  a_stall;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic [15:0] b_stall;

    int checks = 0;
    int passes = 0;

    pipe_stage_reg #(.WIDTH(32), .NOP_VAL(32'h13), .SKID(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_reg #(.WIDTH(32), .NOP_VAL(32'h13), .SKID(0), .CNT_W(16)) u_noskid (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cnt(b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (a_in_ready !== 1'b0) $display("FAIL reset_in_ready act=%b exp=0", a_in_ready); else passes++;
        tick();
        checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid act=%b exp=0", a_out_valid); else passes++;
        checks++; if (a_out_data !== NOP) $display("FAIL reset_out_data act=%h exp=%h", a_out_data, NOP); else passes++;
        checks++; if (a_occ !== 2'd0) $display("FAIL reset_occ act=%0d exp=0", a_occ); else passes++;
        checks++; if (a_stall !== 4'd0) $display("FAIL reset_stall act=%0d exp=0", a_stall); else passes++;
        checks++; if (b_out_valid !== 1'b0) $display("FAIL reset_b_out_valid act=%b exp=0", b_out_valid); else passes++;
        rst = 1'b0;
        #1;
        checks++; if (a_in_ready !== 1'b1) $display("FAIL reset_release_ready act=%b exp=1", a_in_ready); else passes++;
    endtask

    task automatic test_stream();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a_in_data = 32'(i);
            #1;
            checks++; if (a_in_ready !== 1'b1) $display("FAIL stream_ready_%0d act=%b exp=1", i, a_in_ready); else passes++;
            tick();
            checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'(i)) $display("FAIL stream_data_%0d act=%b/%h exp=1/%h", i, a_out_valid, a_out_data, 32'(i)); else passes++;
            checks++; if (a_occ !== 2'd1) $display("FAIL stream_occ_%0d act=%0d exp=1", i, a_occ); else passes++;
        end
        a_in_valid = 1'b0;
        tick();
        checks++; if (a_out_valid !== 1'b0 || a_out_data !== NOP) $display("FAIL stream_drain act=%b/%h exp=0/%h", a_out_valid, a_out_data, NOP); else passes++;
        checks++; if (a_stall !== 4'd0) $display("FAIL stream_stall act=%0d exp=0", a_stall); else passes++;
    endtask

    task automatic test_skid_order();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'hA;
        tick();
        a_in_data = 32'hB;
        #1;
        checks++; if (a_in_ready !== 1'b1) $display("FAIL skid_ready_b act=%b exp=1", a_in_ready); else passes++;
        tick();
        checks++; if (a_occ !== 2'd2) $display("FAIL skid_occ2 act=%0d exp=2", a_occ); else passes++;
        checks++; if (a_out_data !== 32'hA) $display("FAIL skid_head_a act=%h exp=a", a_out_data); else passes++;
        a_in_data = 32'hC;
        #1;
        checks++; if (a_in_ready !== 1'b0) $display("FAIL skid_full_ready act=%b exp=0", a_in_ready); else passes++;
        tick();
        checks++; if (a_out_data !== 32'hA || a_occ !== 2'd2) $display("FAIL skid_hold act=%h/%0d exp=a/2", a_out_data, a_occ); else passes++;
        checks++; if (a_stall !== 4'd2) $display("FAIL skid_stall act=%0d exp=2", a_stall); else passes++;
        a_out_ready = 1'b1;
        tick();
        checks++; if (a_out_data !== 32'hB || a_occ !== 2'd1) $display("FAIL skid_out_b act=%h/%0d exp=b/1", a_out_data, a_occ); else passes++;
        tick();
        checks++; if (a_out_data !== 32'hC || a_occ !== 2'd1) $display("FAIL skid_out_c act=%h/%0d exp=c/1", a_out_data, a_occ); else passes++;
        a_in_valid = 1'b0;
        tick();
        checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) $display("FAIL skid_empty act=%b/%0d exp=0/0", a_out_valid, a_occ); else passes++;
    endtask

    task automatic test_flush();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h21;
        tick();
        a_in_data = 32'h22;
        tick();
        checks++; if (a_occ !== 2'd2) $display("FAIL flush_pre_occ act=%0d exp=2", a_occ); else passes++;
        a_flush   = 1'b1;
        a_in_data = 32'h23;
        tick();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || a_out_data !== NOP || a_occ !== 2'd0) $display("FAIL flush_full act=%b/%h/%0d exp=0/%h/0", a_out_valid, a_out_data, a_occ, NOP); else passes++;
        checks++; if (a_stall !== 4'd4) $display("FAIL flush_stall act=%0d exp=4", a_stall); else passes++;
        a_in_valid = 1'b1;
        a_in_data  = 32'h31;
        tick();
        a_flush   = 1'b1;
        a_in_data = 32'h32;
        #1;
        checks++; if (a_in_ready !== 1'b1) $display("FAIL flush_ready act=%b exp=1", a_in_ready); else passes++;
        tick();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        tick();
        checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) $display("FAIL flush_drop act=%b/%0d exp=0/0", a_out_valid, a_occ); else passes++;
        checks++; if (a_stall !== 4'd5) $display("FAIL flush_stall2 act=%0d exp=5", a_stall); else passes++;
    endtask

    task automatic test_reset_midflight();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h41;
        tick();
        a_in_data = 32'h42;
        tick();
        a_in_valid = 1'b0;
        tick();
        checks++; if (a_stall !== 4'd7 || a_occ !== 2'd2) $display("FAIL midrst_pre act=%0d/%0d exp=7/2", a_stall, a_occ); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (a_in_ready !== 1'b0) $display("FAIL midrst_ready act=%b exp=0", a_in_ready); else passes++;
        tick();
        rst = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || a_out_data !== NOP || a_occ !== 2'd0 || a_stall !== 4'd0) $display("FAIL midrst_state act=%b/%h/%0d/%0d exp=0/%h/0/0", a_out_valid, a_out_data, a_occ, a_stall, NOP); else passes++;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h55;
        tick();
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h55) $display("FAIL midrst_push act=%b/%h exp=1/55", a_out_valid, a_out_data); else passes++;
        tick();
    endtask

    task automatic test_saturate();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h66;
        tick();
        a_in_valid = 1'b0;
        repeat (10) tick();
        checks++; if (a_stall !== 4'd10) $display("FAIL sat_mid act=%0d exp=10", a_stall); else passes++;
        repeat (10) tick();
        checks++; if (a_stall !== 4'd15) $display("FAIL sat_cap act=%0d exp=15", a_stall); else passes++;
        checks++; if (a_out_data !== 32'h66 || a_occ !== 2'd1) $display("FAIL sat_hold act=%h/%0d exp=66/1", a_out_data, a_occ); else passes++;
        a_out_ready = 1'b1;
        tick();
        checks++; if (a_out_valid !== 1'b0 || a_stall !== 4'd15) $display("FAIL sat_drain act=%b/%0d exp=0/15", a_out_valid, a_stall); else passes++;
    endtask

    task automatic test_back_to_back();
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 32'h61;
        #1;
        checks++; if (b_in_ready !== 1'b1) $display("FAIL b2b_empty_ready act=%b exp=1", b_in_ready); else passes++;
        tick();
        b_in_data = 32'h64;
        #1;
        checks++; if (b_in_ready !== 1'b0) $display("FAIL b2b_blocked_ready act=%b exp=0", b_in_ready); else passes++;
        tick();
        checks++; if (b_out_data !== 32'h61 || b_occ !== 2'd1) $display("FAIL b2b_hold act=%h/%0d exp=61/1", b_out_data, b_occ); else passes++;
        b_out_ready = 1'b1;
        b_in_data   = 32'h62;
        #1;
        checks++; if (b_in_ready !== 1'b1) $display("FAIL b2b_comb_ready act=%b exp=1", b_in_ready); else passes++;
        tick();
        checks++; if (b_out_data !== 32'h62 || b_occ !== 2'd1) $display("FAIL b2b_x62 act=%h/%0d exp=62/1", b_out_data, b_occ); else passes++;
        b_in_data = 32'h63;
        tick();
        checks++; if (b_out_data !== 32'h63 || b_occ !== 2'd1) $display("FAIL b2b_x63 act=%h/%0d exp=63/1", b_out_data, b_occ); else passes++;
        b_in_valid = 1'b0;
        tick();
        checks++; if (b_out_valid !== 1'b0 || b_out_data !== NOP) $display("FAIL b2b_empty act=%b/%h exp=0/%h", b_out_valid, b_out_data, NOP); else passes++;
        checks++; if (b_stall !== 16'd1) $display("FAIL b2b_stall act=%0d exp=1", b_stall); else passes++;
    endtask

    initial begin
        rst         = 1'b1;
        a_flush     = 1'b0;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_out_ready = 1'b0;
        b_flush     = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_out_ready = 1'b0;

        test_reset();
        test_stream();
        test_skid_order();
        test_flush();
        test_reset_midflight();
        test_saturate();
        test_back_to_back();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
